// File: rtl/por_status_reporter.sv
// Synchronizes/debounces two POR indications and reports power-up progress on status/checkbits.
// Optional serial state report on uart_tx when POR_STATUS_UART_EN is defined.
module por_status_reporter #(
  parameter int unsigned DEBOUNCE       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned BAUD_DIV       = 4167
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       cfg_done,
  input  logic       por1_ok,
  input  logic       por2_ok,
  output logic [1:0] status,
  output logic [3:0] checkbits,
  output logic       status_oeb,
  output logic       uart_tx
);

  localparam int unsigned     DB_W    = 8;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic            TO_EN   = 1'(TIMEOUT_CYCLES != 0);

  if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
    $error("por_status_reporter: DEBOUNCE must be 1..255");
  end
  if (BAUD_DIV < 1) begin : g_bad_baud
    $error("por_status_reporter: BAUD_DIV must be at least 1");
  end

  // State encoding doubles as the status code.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_POR2_UP = 2'b11,
    S_FAULT   = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      por1_sync;
  logic [1:0]      por2_sync;
  logic [1:0]      sync_lvl;
  logic [1:0]      acc;
  logic [DB_W-1:0] db_cnt [2];
  logic [TO_W-1:0] dwell;
  logic            timeout_c;
  logic [1:0]      status_nxt;
  logic [3:0]      checkbits_nxt;
  logic            oeb_nxt;

  // Two-flop synchronizers for the asynchronous POR indications.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      por1_sync <= '0;
      por2_sync <= '0;
    end else begin
      por1_sync <= {por1_sync[0], por1_ok};
      por2_sync <= {por2_sync[0], por2_ok};
    end
  end

  assign sync_lvl = {por2_sync[1], por1_sync[1]};

  // Debounce: index 0 is por1, index 1 is por2.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      acc <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_lvl[i] == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          acc[i]    <= ~acc[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Fires on the cycle whose edge would complete TIMEOUT_CYCLES of ARMED dwell.
  assign timeout_c = TO_EN && (dwell == TO_LAST);

  always_comb begin
    state_nxt     = state;
    status_nxt    = 2'b00;
    checkbits_nxt = 4'h0;
    oeb_nxt       = 1'b1;
    case (state)
      S_IDLE: begin
        if (cfg_done && acc[0]) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        status_nxt    = 2'b01;
        checkbits_nxt = 4'h9;
        oeb_nxt       = 1'b0;
        if (!acc[0])        state_nxt = S_IDLE;
        else if (acc[1])    state_nxt = S_POR2_UP;
        else if (timeout_c) state_nxt = S_FAULT;
      end
      S_POR2_UP: begin
        status_nxt    = 2'b11;
        checkbits_nxt = 4'h5;
        oeb_nxt       = 1'b0;
        if (!acc[0])      state_nxt = S_IDLE;
        else if (!acc[1]) state_nxt = S_ARMED;
      end
      S_FAULT: begin
        status_nxt    = 2'b10;
        checkbits_nxt = 4'hA;
        oeb_nxt       = 1'b0;
        if (!acc[0]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Dwell counter restarts on every ARMED entry; outputs lag the state register by one cycle.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      dwell      <= '0;
      status     <= 2'b00;
      checkbits  <= 4'h0;
      status_oeb <= 1'b1;
    end else begin
      dwell      <= (state == S_ARMED && state_nxt == S_ARMED) ? dwell + TO_W'(1) : '0;
      status     <= status_nxt;
      checkbits  <= checkbits_nxt;
      status_oeb <= oeb_nxt;
    end
  end

`ifdef POR_STATUS_UART_EN
  localparam int unsigned     BD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BD_W-1:0] BD_LAST = BD_W'(BAUD_DIV - 1);

  logic [7:0]      entry_byte;
  logic            pend_vld;
  logic [7:0]      pend_byte;
  logic            busy;
  logic [8:0]      shift;
  logic [3:0]      bit_cnt;
  logic [BD_W-1:0] baud_cnt;
  logic            tx_q;

  always_comb begin
    entry_byte = 8'h49;
    case (state_nxt)
      S_IDLE:    entry_byte = 8'h49;
      S_ARMED:   entry_byte = 8'h41;
      S_POR2_UP: entry_byte = 8'h50;
      S_FAULT:   entry_byte = 8'h46;
      default:   entry_byte = 8'h49;
    endcase
  end

  // One-deep pending byte feeding an 8N1 transmitter; a newer entry replaces an unstarted byte.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      busy      <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      tx_q      <= 1'b1;
    end else begin
      if (state_nxt != state) begin
        pend_vld  <= 1'b1;
        pend_byte <= entry_byte;
      end else if (!busy && pend_vld) begin
        pend_vld <= 1'b0;
      end

      if (!busy) begin
        if (pend_vld) begin
          busy     <= 1'b1;
          tx_q     <= 1'b0;
          shift    <= {1'b1, pend_byte};
          bit_cnt  <= '0;
          baud_cnt <= '0;
        end
      end else if (baud_cnt == BD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          tx_q <= 1'b1;
        end else begin
          tx_q    <= shift[0];
          shift   <= {1'b1, shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BD_W'(1);
      end
    end
  end

  assign uart_tx = tx_q;
`else
  assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_por_status_reporter.sv
// Self-checking bench for por_status_reporter: vector table, directed corner sequences,
// and randomized stimulus against a window/timestamp reference model.
module tb_por_status_reporter;

  localparam int DEB  = 5;
  localparam int TO   = 100;
  localparam int BAUD = 4;
  localparam int LAT  = 2 + DEB + 2;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_P2    = 2;
  localparam int M_FAULT = 3;

  logic       clock;
  logic       resetb;
  logic       cfg_done;
  logic       por1_ok;
  logic       por2_ok;
  logic [1:0] status;
  logic [3:0] checkbits;
  logic       status_oeb;
  logic       uart_tx;

  por_status_reporter #(
    .DEBOUNCE      (DEB),
    .TIMEOUT_CYCLES(TO),
    .BAUD_DIV      (BAUD)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .cfg_done  (cfg_done),
    .por1_ok   (por1_ok),
    .por2_ok   (por2_ok),
    .status    (status),
    .checkbits (checkbits),
    .status_oeb(status_oeb),
    .uart_tx   (uart_tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] st_code [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [3:0] cb_code [4] = '{4'h0, 4'h9, 4'h5, 4'hA};
  int         m_cyc = 0;
  int         m_state = M_IDLE;
  int         m_entry = 0;
  bit         m_acc1, m_acc2;
  bit         q1[$], q2[$];
  bit         w1[$], w2[$];
  logic [1:0] e_status = 2'b00;
  logic [3:0] e_chk = 4'h0;
  logic       e_oeb = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  function automatic bit window_flips(input bit w[$], input bit lvl);
    if (w.size() < DEB) return 1'b0;
    foreach (w[k]) if (w[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_state = M_IDLE;
    m_acc1 = 1'b0;
    m_acc2 = 1'b0;
    q1 = '{1'b0, 1'b0};
    q2 = '{1'b0, 1'b0};
    w1.delete();
    w2.delete();
    e_status = 2'b00;
    e_chk = 4'h0;
    e_oeb = 1'b1;
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit s1, s2;
    int ns;
    m_cyc++;
    if (resetb !== 1'b1) begin
      m_reset();
      return;
    end
    e_status = st_code[m_state];
    e_chk    = cb_code[m_state];
    e_oeb    = (m_state == M_IDLE);
    ns = m_state;
    if (m_state != M_IDLE && !m_acc1) ns = M_IDLE;
    else begin
      case (m_state)
        M_IDLE:  if (cfg_done === 1'b1 && m_acc1) ns = M_ARMED;
        M_ARMED: if (m_acc2) ns = M_P2;
                 else if (TO != 0 && m_cyc - m_entry == TO) ns = M_FAULT;
        M_P2:    if (!m_acc2) ns = M_ARMED;
        default: ;
      endcase
    end
    if (ns == M_ARMED && m_state != M_ARMED) m_entry = m_cyc;
    m_state = ns;
    s1 = q1.pop_front();
    q1.push_back(por1_ok);
    s2 = q2.pop_front();
    q2.push_back(por2_ok);
    w1.push_back(s1);
    if (w1.size() > DEB) void'(w1.pop_front());
    w2.push_back(s2);
    if (w2.size() > DEB) void'(w2.pop_front());
    if (window_flips(w1, m_acc1)) m_acc1 = !m_acc1;
    if (window_flips(w2, m_acc2)) m_acc2 = !m_acc2;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check("model_status", 32'(status), 32'(e_status));
    check("model_checkbits", 32'(checkbits), 32'(e_chk));
    check("model_oeb", 32'(status_oeb), 32'(e_oeb));
`ifdef POR_STATUS_UART_EN
    if (resetb !== 1'b1) check("uart_idle_in_reset", 32'(uart_tx), 32'd1);
`else
    check("uart_tied_high", 32'(uart_tx), 32'd1);
`endif
  endtask

  task automatic wait_status(input logic [1:0] want, input int bound, input string name,
                             output int n);
    n = 0;
    while (status !== want && n < bound) begin
      step();
      n++;
    end
    check(name, 32'(status), 32'(want));
  endtask

`ifdef POR_STATUS_UART_EN
  task automatic wait_frame(input logic [7:0] b, input string name);
    logic [9:0] fr;
    int n;
    int bad;
    fr = {1'b1, b, 1'b0};
    n = 0;
    while (uart_tx !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    bad = 0;
    for (int c = 0; c < 10 * BAUD; c++) begin
      if (c != 0) step();
      if (uart_tx !== fr[c / BAUD]) bad++;
    end
    check(name, 32'(bad), 32'd0);
  endtask
`endif

  typedef struct {
    logic       rb;
    logic       cfg;
    logic       p1;
    logic       p2;
    int         hold;
    logic [1:0] st;
    logic [3:0] cb;
    logic       oeb;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int n;
    int r1, r2, rc;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 10,  2'b00, 4'h0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5,   2'b00, 4'h0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 20,  2'b00, 4'h0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3,   2'b01, 4'h9, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 9,   2'b11, 4'h5, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 20,  2'b11, 4'h5, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9,   2'b01, 4'h9, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 95,  2'b01, 4'h9, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4,   2'b01, 4'h9, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1,   2'b10, 4'hA, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 20,  2'b10, 4'hA, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 9,   2'b00, 4'h0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 9,   2'b01, 4'h9, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1,   2'b11, 4'h5, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 9,   2'b01, 4'h9, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 4,   2'b01, 4'h9, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 10,  2'b01, 4'h9, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 9,   2'b11, 4'h5, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 5,   2'b11, 4'h5, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 4,   2'b01, 4'h9, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 5,   2'b11, 4'h5, 1'b0};

    resetb = 1'b0;
    cfg_done = 1'b0;
    por1_ok = 1'b0;
    por2_ok = 1'b0;
    m_reset();

    // Reset with random inputs
    for (int i = 0; i < 80; i++) begin
      cfg_done = 1'($urandom_range(0, 1));
      por1_ok  = 1'($urandom_range(0, 1));
      por2_ok  = 1'($urandom_range(0, 1));
      step();
    end
    check("reset_status", 32'(status), 32'd0);
    check("reset_checkbits", 32'(checkbits), 32'd0);
    check("reset_oeb", 32'(status_oeb), 32'd1);
    check("reset_uart", 32'(uart_tx), 32'd1);

    // Vector table
    for (int v = 0; v < 21; v++) begin
      resetb = tbl[v].rb;
      cfg_done = tbl[v].cfg;
      por1_ok = tbl[v].p1;
      por2_ok = tbl[v].p2;
      for (int h = 0; h < tbl[v].hold; h++) step();
      check($sformatf("vec%0d_status", v), 32'(status), 32'(tbl[v].st));
      check($sformatf("vec%0d_checkbits", v), 32'(checkbits), 32'(tbl[v].cb));
      check($sformatf("vec%0d_oeb", v), 32'(status_oeb), 32'(tbl[v].oeb));
    end

    // Reset mid-operation in POR2_UP, then recovery with inputs held high
    resetb = 1'b0;
    step();
    step();
    resetb = 1'b1;
    cfg_done = 1'b1;
    por1_ok = 1'b1;
    por2_ok = 1'b1;
    wait_status(2'b01, 40, "seqA_armed", n);
    check("seqA_arm_latency", 32'(n), 32'(LAT));
    wait_status(2'b11, 10, "seqA_por2", n);
    check("seqA_passthrough", 32'(n), 32'd1);
    repeat (5) step();
    resetb = 1'b0;
    step();
    check("seqA_reset_status", 32'(status), 32'd0);
    check("seqA_reset_oeb", 32'(status_oeb), 32'd1);
    resetb = 1'b1;
    wait_status(2'b01, 40, "seqA_rearm", n);
    wait_status(2'b11, 10, "seqA_repor2", n);
    check("seqA_repassthrough", 32'(n), 32'd1);

    // Timeout measured from ARMED to FAULT on the status pads
    resetb = 1'b0;
    por2_ok = 1'b0;
    step();
    resetb = 1'b1;
    wait_status(2'b01, 40, "seqB_armed", n);
    wait_status(2'b10, 3 * TO, "seqB_fault", n);
    check("seqB_timeout_cycles", 32'(n), 32'(TO));
    check("seqB_fault_checkbits", 32'(checkbits), 32'hA);
    por1_ok = 1'b0;
    wait_status(2'b00, 40, "seqB_idle", n);
    check("seqB_idle_latency", 32'(n), 32'(LAT));

    // Normal power-up (UART frames when enabled)
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    cfg_done = 1'b1;
    por1_ok = 1'b1;
    por2_ok = 1'b0;
`ifdef POR_STATUS_UART_EN
    wait_frame(8'h41, "seqC_uart_A");
`else
    repeat (60) step();
`endif
    check("seqC_armed", 32'(status), 32'd1);
    por2_ok = 1'b1;
    wait_status(2'b11, 40, "seqC_por2", n);
    check("seqC_por2_latency", 32'(n), 32'(LAT));
`ifdef POR_STATUS_UART_EN
    wait_frame(8'h50, "seqC_uart_P");
`endif

    // Randomized segments with varying toggle rates
    for (int seg = 0; seg < 12; seg++) begin
      r1 = int'($urandom_range(6, 200));
      r2 = int'($urandom_range(4, 300));
      rc = int'($urandom_range(5, 80));
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, r1 - 1) == 0) por1_ok = !por1_ok;
        if ($urandom_range(0, r2 - 1) == 0) por2_ok = !por2_ok;
        if ($urandom_range(0, rc - 1) == 0) cfg_done = !cfg_done;
        resetb = ($urandom_range(0, 599) != 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/por_status_reporter.md
Name: por_status_reporter

Overview:
- User-project block in the caravan analog wrapper that reports power-on-reset (POR) progress on GPIO pads.
- Synchronizes the two POR indications (core-domain POR and the second, separately powered POR) and runs a small FSM.
- Drives a 2-bit status code (HV readback pads) and a 4-bit checkbits pattern (LV readback pads), so an external bench can follow the power-up sequence.
- The pad mapping (status on mprj_io[25],[10]; checkbits on mprj_io[27:26],[12:11]) is done at wrapper level, not in this block.

Parameters:
- DEBOUNCE, 16, consecutive synchronized cycles a POR input must hold a new level before it is accepted (1..255).
- TIMEOUT_CYCLES, 1000000, maximum cycles in ARMED waiting for the second POR; 0 disables the timeout.
- BAUD_DIV, 4167, clock cycles per UART bit (40 MHz / 9600 baud); used only with the optional feature.

Ports:
- clock  in  1  system clock (25 ns period nominal).
- resetb  in  1  reset, synchronous, active-low.
- cfg_done  in  1  level; management firmware has finished GPIO configuration.
- por1_ok  in  1  asynchronous; core-domain POR released (1 = powered).
- por2_ok  in  1  asynchronous; second POR released (1 = powered, derived from mprj_io[18] supply).
- status  out  2  state code: 00 IDLE, 01 ARMED, 11 POR2_UP, 10 FAULT.
- checkbits  out  4  state signature: IDLE 0x0, ARMED 0x9, POR2_UP 0x5, FAULT 0xA.
- status_oeb  out  1  pad output-enable, active-low; 0 whenever resetb=1 and the FSM is not in IDLE, else 1.
- uart_tx  out  1  serial state report; idle high.

Behaviour:
- Single clock domain; every flop resets synchronously when resetb=0 at a clock rising edge.
- Reset values: status=00, checkbits=0x0, status_oeb=1, uart_tx=1, all counters 0, debounced POR levels 0.
- Synchronization: por1_ok and por2_ok each pass through a 2-flop synchronizer (reset to 0).
- Debounce: a per-input counter runs while the synchronized value differs from the accepted level and clears on any match. When the counter reaches DEBOUNCE, the accepted level flips.
- Input-to-accepted latency is 2 + DEBOUNCE cycles.
- Outputs are registered and decoded from the state register, so they change one cycle after the transition decision.

FSM transitions:
- IDLE -> ARMED: when cfg_done=1 and accepted por1=1.
- ARMED -> POR2_UP: when accepted por2=1.
- ARMED -> FAULT: when TIMEOUT_CYCLES != 0 and the ARMED dwell counter reaches TIMEOUT_CYCLES. The counter clears on entry to ARMED.
- POR2_UP -> ARMED: when accepted por2 returns to 0 (second supply lost); the dwell counter restarts.
- Any state except IDLE -> IDLE: when accepted por1=0 (highest priority).
- FAULT is sticky until accepted por1=0 or reset.
- Same-cycle events: if por2 acceptance and timeout occur together in ARMED, POR2_UP wins.
- If accepted por2=1 already when IDLE exits, the FSM passes through ARMED for exactly one cycle and then enters POR2_UP.
- cfg_done falling after IDLE has no effect.
- A reset asserted mid-operation returns the FSM to IDLE on the next edge regardless of state; any UART frame in progress is aborted with uart_tx=1.

Optional Feature:
- Macro: POR_STATUS_UART_EN.
- When defined: each state entry (excluding reset) queues one ASCII byte for transmission on uart_tx, sent 8N1, LSB first, BAUD_DIV cycles per bit.
  - Byte values: 'I' 0x49, 'A' 0x41, 'P' 0x50, 'F' 0x46.
  - The queue is a one-deep pending register. A newer state overwrites a pending (not yet started) byte; a frame already in progress always completes.
- When undefined: uart_tx is tied to 1 and no UART logic is synthesized; all other behaviour is identical.

Test Plan:
- Reset: resetb=0 for 80 cycles with random inputs -> status=00, checkbits=0x0, status_oeb=1, uart_tx=1.
- Normal power-up: por1_ok=1, cfg_done=1 -> status=01 and checkbits=0x9 within 2+DEBOUNCE+2 cycles. Then por2_ok=1 after 6000 cycles -> status=11 and checkbits=0x5 within 2+DEBOUNCE+2 cycles.
- Glitch rejection: in ARMED, pulse por2_ok high for DEBOUNCE-1 cycles -> status stays 01. Then drop por2_ok in POR2_UP for DEBOUNCE cycles -> status=01, checkbits=0x9.
- Timeout: TIMEOUT_CYCLES=100, por2_ok held 0 -> status=10 and checkbits=0xA exactly 100 cycles after ARMED entry. por1_ok=0 afterwards -> status=00.
- Reset mid-operation: in POR2_UP, assert resetb=0 for 1 cycle -> status=00 on the next edge. After release with inputs still high -> ARMED, then POR2_UP.
- With POR_STATUS_UART_EN, BAUD_DIV=4: normal power-up -> uart_tx carries 0x41 then 0x50, start bit 0, stop bit 1, each bit 4 cycles wide.
